cfa_window_5x5: RTL

Raster-to-window front end for the CFA interpolation pipeline. It accepts one 12-bit Bayer pixel per qualified cycle in raster order and keeps four line buffers plus a 5x5 register window. For every input pixel whose 5x5 neighbourhood lies fully inside the frame, it presents that neighbourhood to the gradient stage directly downstream. `win_valid` drives that stage's `start` input, and the 25 window taps map one-to-one onto its `p_<row>_<col>` pixel inputs.

---
 rtl/cfa_pkg.sv | 10 +
 rtl/cfa_window_5x5_if.sv | 26 ++
 rtl/cfa_line_buf.sv | 17 +
 rtl/cfa_window_5x5.sv | 88 ++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// cfa_pkg: shared constants, FSM encoding and window indexing for the CFA front end
package cfa_pkg;
  localparam int PIX_W = 12;
  localparam int WIN_N = 5;
  localparam int WIN_HALF = 2;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int idx(input int r, input int c);
    return WIN_N * r + c;
  endfunction
endpackage

// File: rtl/cfa_window_5x5_if.sv
// cfa_window_5x5_if: raster pixel input and 5x5 window output bundle
interface cfa_window_5x5_if
  import cfa_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = cfa_pkg::PIX_W
);
  logic [PIX_W-1:0] pix_in;
  logic pix_valid;
  logic sof;
  logic [WIN_N*WIN_N*PIX_W-1:0] win;
  logic win_valid;
  logic [$clog2(IMG_W)-1:0] ctr_x;
  logic [$clog2(IMG_H)-1:0] ctr_y;
  logic frame_done;
  logic sync_err;
  modport master (
    output pix_in, pix_valid, sof,
    input win, win_valid, ctr_x, ctr_y, frame_done, sync_err
  );
  modport slave (
    input pix_in, pix_valid, sof,
    output win, win_valid, ctr_x, ctr_y, frame_done, sync_err
  );
endinterface

// File: rtl/cfa_line_buf.sv
// cfa_line_buf: one line of pixel storage, combinational read and synchronous write at one address
module cfa_line_buf #(
  parameter int DEPTH = 640,
  parameter int W = 12,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] addr,
  input logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [DEPTH];
  // write the incoming value after the old one has been read out
  always_ff @(posedge clk) if (we) mem[addr] <= din;
  assign dout = mem[addr];
endmodule

// File: rtl/cfa_window_5x5.sv
// cfa_window_5x5: raster-to-5x5-window front end with frame sync tracking
module cfa_window_5x5
  import cfa_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = cfa_pkg::PIX_W
) (
  input logic clk,
  input logic rst,
  cfa_window_5x5_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  state_t state, nxt;
  logic [XW-1:0] col, cur_col;
  logic [YW-1:0] row, cur_row;
  logic start, acc, drop, last, qual, col_end;
  logic [PIX_W-1:0] t [WIN_N];
  logic [PIX_W-1:0] w [WIN_N][WIN_N];
  // FSM state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // FSM next state: a sof pixel always (re)starts, the last pixel ends the frame
  always_comb nxt = last ? IDLE : start ? RUN : state;
  // FSM outputs: pixel acceptance and position of the accepted pixel
  always_comb begin
    start = bus.pix_valid & bus.sof;
    acc = bus.pix_valid & (bus.sof | state == RUN);
    drop = bus.pix_valid & ~bus.sof & state == IDLE;
    cur_col = start ? '0 : col;
    cur_row = start ? '0 : row;
    col_end = cur_col == XW'(IMG_W - 1);
    last = acc & col_end & cur_row == YW'(IMG_H - 1);
    qual = acc & cur_col >= XW'(WIN_N - 1) & cur_row >= YW'(WIN_N - 1);
  end
  // raster position of the next expected pixel
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      col <= col_end ? '0 : cur_col + 1'b1;
      row <= last ? '0 : cur_row + YW'(col_end);
    end
  assign t[0] = bus.pix_in;
  for (genvar i = 0; i < WIN_N - 1; i++) begin : g_lb
    cfa_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb (
      .clk(clk),
      .we(acc & ~rst),
      .addr(cur_col),
      .din(t[i]),
      .dout(t[i+1])
    );
  end
  // shift the window left and load the new column, oldest line on row 0
  always_ff @(posedge clk)
    if (rst) begin
      for (int r = 0; r < WIN_N; r++)
        for (int c = 0; c < WIN_N; c++) w[r][c] <= '0;
    end else if (acc) begin
      for (int r = 0; r < WIN_N; r++) begin
        for (int c = 0; c < WIN_N - 1; c++) w[r][c] <= w[r][c+1];
        w[r][WIN_N-1] <= t[WIN_N-1-r];
      end
    end
  // registered status: window pulse, centre, frame end and sticky sync error
  always_ff @(posedge clk)
    if (rst) begin
      bus.win_valid <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.sync_err <= 1'b0;
      bus.ctr_x <= '0;
      bus.ctr_y <= '0;
    end else begin
      bus.win_valid <= qual;
      bus.frame_done <= last;
      bus.sync_err <= bus.sync_err | drop;
      if (qual) begin
        bus.ctr_x <= cur_col - XW'(WIN_HALF);
        bus.ctr_y <= cur_row - YW'(WIN_HALF);
      end
    end
  for (genvar r = 0; r < WIN_N; r++) begin : g_r
    for (genvar c = 0; c < WIN_N; c++) begin : g_c
      assign bus.win[idx(r, c)*PIX_W +: PIX_W] = w[r][c];
    end
  end
endmodule
